// File: rtl/pc_sequencer_if.sv
// Fetch-PC bus between the redirect/trap sources and pc_sequencer.
// The trace signals are live only when PC_SEQ_TRACE_EN is defined in the sequencer.
interface pc_sequencer_if #(
   parameter int XLEN        = 32,
   parameter int CNT_W       = 64,
   parameter int TRACE_DEPTH = 8
);
   localparam int TIW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

   logic             stall_i;
   logic             redirect_i;
   logic [XLEN-1:0]  redirect_target_i;
   logic             trap_i;
   logic [XLEN-1:0]  trap_vector_i;
   logic [TIW-1:0]   trace_idx_i;
   logic [XLEN-1:0]  PC;
   logic [XLEN-1:0]  PC_OUT;
   logic             misalign_o;
   logic [XLEN-1:0]  bad_addr_o;
   logic [CNT_W-1:0] retired_o;
   logic [XLEN-1:0]  trace_pc_o;
   logic             trace_valid_o;

   modport master (
      output stall_i, redirect_i, redirect_target_i, trap_i, trap_vector_i, trace_idx_i,
      input  PC, PC_OUT, misalign_o, bad_addr_o, retired_o, trace_pc_o, trace_valid_o
   );

   modport slave (
      input  stall_i, redirect_i, redirect_target_i, trap_i, trap_vector_i, trace_idx_i,
      output PC, PC_OUT, misalign_o, bad_addr_o, retired_o, trace_pc_o, trace_valid_o
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register with trap > redirect > stall > increment selection and retire counter.
// Optional PC trace buffer built when PC_SEQ_TRACE_EN is defined.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INC_BYTES    = 4,
   parameter int              CNT_W        = 64,
   parameter int              TRACE_DEPTH  = 8
) (
   input  logic         CLK,
   input  logic         RST,
   pc_sequencer_if.slave bus
);
   localparam int              TIW        = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
   localparam logic [XLEN-1:0] INC        = XLEN'(INC_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC_BYTES - 1);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mis_q, mis_d;
   logic [XLEN-1:0]  bad_q, bad_d;
   logic             adv;
   logic [XLEN-1:0]  tgt;
   logic             tgt_bad;

   // JALR clears bit 0 before the alignment check
   assign tgt     = bus.redirect_target_i & ~XLEN'(1);
   assign tgt_bad = |(tgt & ALIGN_MASK);

   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      mis_d = 1'b0;
      bad_d = bad_q;
      adv   = 1'b0;
      if (bus.trap_i) begin
         pc_d = bus.trap_vector_i & ~ALIGN_MASK;
         adv  = 1'b1;
      end else if (bus.redirect_i) begin
         if (tgt_bad) begin
            mis_d = 1'b1;
            bad_d = tgt;
         end else begin
            pc_d  = tgt;
            cnt_d = cnt_q + CNT_W'(1);
            adv   = 1'b1;
         end
      end else if (!bus.stall_i) begin
         pc_d  = pc_q + INC;
         cnt_d = cnt_q + CNT_W'(1);
         adv   = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q  <= RESET_VECTOR;
         cnt_q <= '0;
         mis_q <= 1'b0;
         bad_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         mis_q <= mis_d;
         bad_q <= bad_d;
      end
   end

   assign bus.PC         = pc_q;
   assign bus.PC_OUT     = pc_q + INC;
   assign bus.misalign_o = mis_q;
   assign bus.bad_addr_o = bad_q;
   assign bus.retired_o  = cnt_q;

`ifdef PC_SEQ_TRACE_EN
   logic [TRACE_DEPTH-1:0][XLEN-1:0] trace_q;
   logic [TIW-1:0]                   wr_ptr_q;
   logic [TIW:0]                     fill_q;
   logic [TIW-1:0]                   rd_ptr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else if (adv) begin
         wr_ptr_q <= wr_ptr_q + TIW'(1);
         if (fill_q != (TIW+1)'(TRACE_DEPTH)) fill_q <= fill_q + (TIW+1)'(1);
      end
   end

   // Storage needs no reset; validity comes from fill_q
   always_ff @(posedge CLK) begin
      if (!RST && adv) trace_q[wr_ptr_q] <= pc_q;
   end

   assign rd_ptr            = wr_ptr_q - TIW'(1) - bus.trace_idx_i;
   assign bus.trace_pc_o    = trace_q[rd_ptr];
   assign bus.trace_valid_o = ({1'b0, bus.trace_idx_i} < fill_q);
`else
   logic unused_trace;
   assign unused_trace      = &{1'b0, bus.trace_idx_i, adv};
   assign bus.trace_pc_o    = '0;
   assign bus.trace_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (XLEN=32, INC_BYTES=4, RESET_VECTOR=0).
module tb_pc_sequencer;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   pc_sequencer_if #(.XLEN(32), .CNT_W(64), .TRACE_DEPTH(8)) bus ();

   pc_sequencer #(
      .XLEN(32), .RESET_VECTOR(32'h0), .INC_BYTES(4), .CNT_W(64), .TRACE_DEPTH(8)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall_i           = 1'b0;
      bus.redirect_i        = 1'b0;
      bus.redirect_target_i = '0;
      bus.trap_i            = 1'b0;
      bus.trap_vector_i     = '0;
      bus.trace_idx_i       = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      idle_inputs();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      checks++;
      if (bus.misalign_o !== 1'b0 || bus.bad_addr_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_flags got mis=%b bad=%h exp mis=0 bad=0", bus.misalign_o, bus.bad_addr_o);
      end
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'(i * 4);
         checks++;
         if (bus.PC !== exp_pc || bus.PC_OUT !== exp_pc + 32'h4 || bus.retired_o !== 64'(i)) begin
            failures++;
            $display("FAIL inc_%0d got pc=%h pc_out=%h ret=%0d exp pc=%h pc_out=%h ret=%0d",
                     i, bus.PC, bus.PC_OUT, bus.retired_o, exp_pc, exp_pc + 32'h4, i);
         end
         if (i < 3) step();
      end
   endtask

   // Enters with PC=0xC, retired=3; rewind to PC=0x8 via reset
   task automatic test_redirect_stall();
      do_reset();
      step();
      step();
      bus.redirect_i        = 1'b1;
      bus.redirect_target_i = 32'h101;
      step();
      bus.redirect_i = 1'b0;
      checks++;
      if (bus.PC !== 32'h100 || bus.retired_o !== 64'd3) begin
         failures++;
         $display("FAIL redirect got pc=%h ret=%0d exp pc=00000100 ret=3", bus.PC, bus.retired_o);
      end
      bus.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.PC !== 32'h100 || bus.retired_o !== 64'd3) begin
            failures++;
            $display("FAIL stall_%0d got pc=%h ret=%0d exp pc=00000100 ret=3", i, bus.PC, bus.retired_o);
         end
      end
      bus.redirect_i        = 1'b1;
      bus.redirect_target_i = 32'h200;
      step();
      bus.redirect_i = 1'b0;
      bus.stall_i    = 1'b0;
      checks++;
      if (bus.PC !== 32'h200 || bus.retired_o !== 64'd4) begin
         failures++;
         $display("FAIL redirect_in_stall got pc=%h ret=%0d exp pc=00000200 ret=4", bus.PC, bus.retired_o);
      end
   endtask

   task automatic test_misalign();
      bus.redirect_i        = 1'b1;
      bus.redirect_target_i = 32'h202;
      step();
      bus.redirect_i = 1'b0;
      checks++;
      if (bus.PC !== 32'h200 || bus.misalign_o !== 1'b1 || bus.bad_addr_o !== 32'h202 ||
          bus.retired_o !== 64'd4) begin
         failures++;
         $display("FAIL misalign got pc=%h mis=%b bad=%h ret=%0d exp pc=00000200 mis=1 bad=00000202 ret=4",
                  bus.PC, bus.misalign_o, bus.bad_addr_o, bus.retired_o);
      end
      bus.trap_i        = 1'b1;
      bus.trap_vector_i = 32'h80000003;
      step();
      bus.trap_i = 1'b0;
      checks++;
      if (bus.PC !== 32'h80000000 || bus.misalign_o !== 1'b0 || bus.bad_addr_o !== 32'h202 ||
          bus.retired_o !== 64'd4) begin
         failures++;
         $display("FAIL trap got pc=%h mis=%b bad=%h ret=%0d exp pc=80000000 mis=0 bad=00000202 ret=4",
                  bus.PC, bus.misalign_o, bus.bad_addr_o, bus.retired_o);
      end
   endtask

   task automatic test_priority_wrap();
      bus.trap_i            = 1'b1;
      bus.trap_vector_i     = 32'hFFFFFFFC;
      bus.redirect_i        = 1'b1;
      bus.redirect_target_i = 32'h300;
      bus.stall_i           = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (bus.PC !== 32'hFFFFFFFC || bus.PC_OUT !== 32'h0 || bus.retired_o !== 64'd4) begin
         failures++;
         $display("FAIL priority got pc=%h pc_out=%h ret=%0d exp pc=fffffffc pc_out=00000000 ret=4",
                  bus.PC, bus.PC_OUT, bus.retired_o);
      end
      step();
      checks++;
      if (bus.PC !== 32'h0 || bus.retired_o !== 64'd5) begin
         failures++;
         $display("FAIL wrap got pc=%h ret=%0d exp pc=00000000 ret=5", bus.PC, bus.retired_o);
      end
   endtask

   task automatic test_reset_mid();
      // Leave a misalign behind so reset has flags to clear
      bus.redirect_i        = 1'b1;
      bus.redirect_target_i = 32'h206;
      step();
      RST                   = 1'b1;
      bus.redirect_target_i = 32'h400;
      step();
      RST = 1'b0;
      idle_inputs();
      checks++;
      if (bus.PC !== 32'h0 || bus.retired_o !== 64'd0 || bus.misalign_o !== 1'b0 ||
          bus.bad_addr_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid got pc=%h ret=%0d mis=%b bad=%h exp pc=00000000 ret=0 mis=0 bad=00000000",
                  bus.PC, bus.retired_o, bus.misalign_o, bus.bad_addr_o);
      end
   endtask

`ifdef PC_SEQ_TRACE_EN
   task automatic test_trace();
      do_reset();
      for (int i = 0; i < 10; i++) step();
      bus.trace_idx_i = 3'd0;
      #1;
      checks++;
      if (bus.trace_pc_o !== 32'h24 || bus.trace_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL trace_idx0 got pc=%h v=%b exp pc=00000024 v=1", bus.trace_pc_o, bus.trace_valid_o);
      end
      bus.trace_idx_i = 3'd7;
      #1;
      checks++;
      if (bus.trace_pc_o !== 32'h08 || bus.trace_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL trace_idx7 got pc=%h v=%b exp pc=00000008 v=1", bus.trace_pc_o, bus.trace_valid_o);
      end
      bus.trace_idx_i = 3'd0;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      bus.trace_idx_i = 3'd2;
      #1;
      checks++;
      if (bus.trace_pc_o !== 32'h0 || bus.trace_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL trace_short_idx2 got pc=%h v=%b exp pc=00000000 v=1", bus.trace_pc_o, bus.trace_valid_o);
      end
      bus.trace_idx_i = 3'd3;
      #1;
      checks++;
      if (bus.trace_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL trace_short_idx3 got v=%b exp v=0", bus.trace_valid_o);
      end
   endtask
`else
   task automatic test_trace();
      do_reset();
      for (int i = 0; i < 5; i++) step();
      for (int i = 0; i < 8; i += 3) begin
         bus.trace_idx_i = 3'(i);
         #1;
         checks++;
         if (bus.trace_pc_o !== 32'h0 || bus.trace_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL trace_off_idx%0d got pc=%h v=%b exp pc=00000000 v=0",
                     i, bus.trace_pc_o, bus.trace_valid_o);
         end
      end
      checks++;
      if (bus.PC !== 32'h14 || bus.retired_o !== 64'd5) begin
         failures++;
         $display("FAIL trace_off_pc got pc=%h ret=%0d exp pc=00000014 ret=5", bus.PC, bus.retired_o);
      end
   endtask
`endif

   initial begin
      idle_inputs();
      test_reset();
      test_redirect_stall();
      test_misalign();
      test_priority_wrap();
      test_reset_mid();
      test_trace();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
